// File: rtl/onehot_pulse_decoder_3_to_8.sv
// 3-bit index to 8-bit one-hot pulse, held for HOLD_CYCLES, then auto-cleared with a done strobe.
// Optional macro DECODER_PENDING_QUEUE_EN adds a 2-entry pending-code FIFO ahead of the pulse FSM.
module onehot_pulse_decoder_3_to_8 #(
  parameter  int HOLD_CYCLES = 4,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       done,
  output logic       busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         out_q, out_d;
  logic               done_q, done_d;
  logic               xfer, launch;
  logic [2:0]         launch_code;
  logic [7:0]         dec;

  assign xfer = in_valid && in_ready;

  for (genvar i = 0; i < 8; i++) begin : g_dec
    assign dec[i] = (launch_code == 3'(i));
  end

`ifdef DECODER_PENDING_QUEUE_EN
  localparam int QD = 2;

  logic [QD-1:0][2:0] q_q, q_d;
  logic [1:0]         qcnt_q, qcnt_d;
  logic               q_empty, q_full, push, pop;

  assign q_empty     = (qcnt_q == 2'd0);
  assign q_full      = (qcnt_q == 2'(QD));
  // A queued head always launches ahead of a code arriving this cycle, keeping order.
  assign pop         = (state_q == IDLE) && !q_empty;
  assign launch      = (state_q == IDLE) && (!q_empty || xfer);
  assign launch_code = q_empty ? in_code : q_q[0];
  assign push        = xfer && !((state_q == IDLE) && q_empty);

  always_comb begin
    q_d    = q_q;
    qcnt_d = qcnt_q;
    if (pop) begin
      q_d[0] = q_q[1];
      qcnt_d = qcnt_q - 2'd1;
    end
    if (push) begin
      // push requires !full, and after a pop the fill level is at most 1
      q_d[qcnt_d[0]] = in_code;
      qcnt_d         = qcnt_d + 2'd1;
    end
    if (flush) qcnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      qcnt_q <= 2'd0;
    end else begin
      q_q    <= q_d;
      qcnt_q <= qcnt_d;
    end
  end
`else
  assign launch      = xfer;
  assign launch_code = in_code;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; flush overrides everything and suppresses done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            out_d   = dec;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            out_d   = 8'h00;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = 8'h00;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    out       = out_q;
    out_valid = |out_q;
    done      = done_q;
    busy      = (state_q == HOLD);
`ifdef DECODER_PENDING_QUEUE_EN
    in_ready  = !q_full;
`else
    in_ready  = (state_q == IDLE);
`endif
  end

endmodule
